// File: rtl/match_req_issuer.sv
// Issues match requests for hashed candidates, tracks them in a reorder buffer,
// and retires match results strictly in allocation order.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef NUM_JOB_PE_LOG2
`define NUM_JOB_PE_LOG2 2
`endif
`ifndef MAX_MATCH_LEN_LOG2
`define MAX_MATCH_LEN_LOG2 8
`endif

module match_req_issuer #(
  parameter int JOB_PE_IDX = 0,
  parameter int ROB_DEPTH  = 8
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_cand_valid,
  output logic                            o_cand_ready,
  input  logic [`ADDR_WIDTH-1:0]          i_cand_head_addr,
  input  logic [`ADDR_WIDTH-1:0]          i_cand_history_addr,
  output logic                            o_match_req_valid,
  input  logic                            i_match_req_ready,
  output logic [`NUM_JOB_PE_LOG2-1:0]     o_match_req_job_pe_id,
  output logic [7:0]                      o_match_req_tag,
  output logic [`ADDR_WIDTH-1:0]          o_match_req_head_addr,
  output logic [`ADDR_WIDTH-1:0]          o_match_req_history_addr,
  input  logic                            i_match_resp_valid,
  output logic                            o_match_resp_ready,
  input  logic [`NUM_JOB_PE_LOG2-1:0]     i_match_resp_job_pe_id,
  input  logic [7:0]                      i_match_resp_tag,
  input  logic [`MAX_MATCH_LEN_LOG2:0]    i_match_resp_match_len,
  output logic                            o_result_valid,
  input  logic                            i_result_ready,
  output logic [`ADDR_WIDTH-1:0]          o_result_head_addr,
  output logic [`ADDR_WIDTH-1:0]          o_result_history_addr,
  output logic [`MAX_MATCH_LEN_LOG2:0]    o_result_match_len,
  output logic [$clog2(ROB_DEPTH):0]      o_outstanding,
  output logic                            o_err
);

  localparam int IW = $clog2(ROB_DEPTH);
  localparam int PW = IW + 1;
  localparam int AW = `ADDR_WIDTH;
  localparam int JW = `NUM_JOB_PE_LOG2;
  localparam int LW = `MAX_MATCH_LEN_LOG2 + 1;

  logic [PW-1:0] alloc_ptr, issue_ptr, retire_ptr;
  logic [AW-1:0] head_mem [ROB_DEPTH];
  logic [AW-1:0] hist_mem [ROB_DEPTH];
  logic [LW-1:0] len_mem  [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] done_q, done_next;
  logic err_q;

  logic [IW-1:0] alloc_idx, issue_idx, retire_idx, resp_idx;
  logic [PW-1:0] used, in_flight, resp_off;
  logic full, cand_fire, req_fire, resp_fire, res_fire;
  logic resp_ok, tag_in_range;

  assign alloc_idx  = alloc_ptr[IW-1:0];
  assign issue_idx  = issue_ptr[IW-1:0];
  assign retire_idx = retire_ptr[IW-1:0];
  assign resp_idx   = i_match_resp_tag[IW-1:0];

  assign used      = alloc_ptr - retire_ptr;
  assign in_flight = issue_ptr - retire_ptr;
  assign full      = (used == PW'(ROB_DEPTH));

  assign o_cand_ready       = !rst && !full;
  assign o_match_req_valid  = !rst && (issue_ptr != alloc_ptr);
  assign o_match_resp_ready = !rst;
  assign o_result_valid     = !rst && (retire_ptr != issue_ptr) && done_q[retire_idx];
  assign o_outstanding      = rst ? '0 : used;
  assign o_err              = err_q;

  assign o_match_req_job_pe_id    = JW'(JOB_PE_IDX);
  assign o_match_req_tag          = 8'(issue_idx);
  assign o_match_req_head_addr    = head_mem[issue_idx];
  assign o_match_req_history_addr = hist_mem[issue_idx];
  assign o_result_head_addr       = head_mem[retire_idx];
  assign o_result_history_addr    = hist_mem[retire_idx];
  assign o_result_match_len       = len_mem[retire_idx];

  assign cand_fire = i_cand_valid && o_cand_ready;
  assign req_fire  = o_match_req_valid && i_match_req_ready;
  assign resp_fire = i_match_resp_valid && o_match_resp_ready;
  assign res_fire  = o_result_valid && i_result_ready;

  // Tag bits above the index must be zero; distance from retire must be below issue.
  assign resp_off     = {1'b0, resp_idx - retire_idx};
  assign tag_in_range = (i_match_resp_tag == 8'(resp_idx)) && (resp_off < in_flight);
  assign resp_ok      = (i_match_resp_job_pe_id == JW'(JOB_PE_IDX)) && tag_in_range
                        && !done_q[resp_idx];

  // Alloc clear applied last so it wins on a reused index.
  always_comb begin
    done_next = done_q;
    if (res_fire)             done_next[retire_idx] = 1'b0;
    if (resp_fire && resp_ok) done_next[resp_idx]   = 1'b1;
    if (cand_fire)            done_next[alloc_idx]  = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alloc_ptr  <= '0;
      issue_ptr  <= '0;
      retire_ptr <= '0;
      done_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      if (cand_fire) alloc_ptr  <= alloc_ptr + 1'b1;
      if (req_fire)  issue_ptr  <= issue_ptr + 1'b1;
      if (res_fire)  retire_ptr <= retire_ptr + 1'b1;
      if (resp_fire && !resp_ok) err_q <= 1'b1;
      done_q <= done_next;
    end
  end

  always_ff @(posedge clk) begin
    if (cand_fire) begin
      head_mem[alloc_idx] <= i_cand_head_addr;
      hist_mem[alloc_idx] <= i_cand_history_addr;
    end
    if (resp_fire && resp_ok) len_mem[resp_idx] <= i_match_resp_match_len;
  end

endmodule

// File: tb/tb_match_req_issuer.sv
// Directed bench for match_req_issuer: ordering, full/backpressure, wrap,
// protocol errors and mid-run reset.
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 16
`endif
`ifndef NUM_JOB_PE_LOG2
`define NUM_JOB_PE_LOG2 2
`endif
`ifndef MAX_MATCH_LEN_LOG2
`define MAX_MATCH_LEN_LOG2 8
`endif

module tb_match_req_issuer;
  localparam int DEPTH = 8;
  localparam int JOB   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic cand_valid, cand_ready;
  logic [`ADDR_WIDTH-1:0] cand_head, cand_hist;
  logic req_valid, req_ready;
  logic [`NUM_JOB_PE_LOG2-1:0] req_job;
  logic [7:0] req_tag;
  logic [`ADDR_WIDTH-1:0] req_head, req_hist;
  logic resp_valid, resp_ready;
  logic [`NUM_JOB_PE_LOG2-1:0] resp_job;
  logic [7:0] resp_tag;
  logic [`MAX_MATCH_LEN_LOG2:0] resp_len;
  logic res_valid, res_ready;
  logic [`ADDR_WIDTH-1:0] res_head, res_hist;
  logic [`MAX_MATCH_LEN_LOG2:0] res_len;
  logic [$clog2(DEPTH):0] outstanding;
  logic err;

  match_req_issuer #(.JOB_PE_IDX(JOB), .ROB_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .i_cand_valid(cand_valid), .o_cand_ready(cand_ready),
    .i_cand_head_addr(cand_head), .i_cand_history_addr(cand_hist),
    .o_match_req_valid(req_valid), .i_match_req_ready(req_ready),
    .o_match_req_job_pe_id(req_job), .o_match_req_tag(req_tag),
    .o_match_req_head_addr(req_head), .o_match_req_history_addr(req_hist),
    .i_match_resp_valid(resp_valid), .o_match_resp_ready(resp_ready),
    .i_match_resp_job_pe_id(resp_job), .i_match_resp_tag(resp_tag),
    .i_match_resp_match_len(resp_len),
    .o_result_valid(res_valid), .i_result_ready(res_ready),
    .o_result_head_addr(res_head), .o_result_history_addr(res_hist),
    .o_result_match_len(res_len),
    .o_outstanding(outstanding), .o_err(err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int exp_tag  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Drives land 1ns after posedge, samples 1ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    #1;
  endtask

  task automatic cand(input logic [`ADDR_WIDTH-1:0] h, input logic [`ADDR_WIDTH-1:0] y);
    cand_valid = 1'b1;
    cand_head  = h;
    cand_hist  = y;
  endtask

  task automatic resp(input int id, input int tag, input int len);
    resp_valid = 1'b1;
    resp_job   = id[`NUM_JOB_PE_LOG2-1:0];
    resp_tag   = tag[7:0];
    resp_len   = len[`MAX_MATCH_LEN_LOG2:0];
  endtask

  task automatic do_reset();
    step();
    rst = 1'b1;
    cand_valid = 1'b0;
    resp_valid = 1'b0;
    sample();
    step();
    rst = 1'b0;
    sample();
    exp_tag = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cand_valid = 1'b0; cand_head = '0; cand_hist = '0;
    req_ready = 1'b1;
    resp_valid = 1'b0; resp_job = '0; resp_tag = '0; resp_len = '0;
    res_ready = 1'b1;

    // reset state
    step(); step(); sample();
    chk("rst_cand_ready", cand_ready, 0);
    chk("rst_req_valid", req_valid, 0);
    chk("rst_resp_ready", resp_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err, 0);
    step(); rst = 1'b0; sample();
    chk("post_rst_cand_ready", cand_ready, 1);
    chk("post_rst_resp_ready", resp_ready, 1);

    // single candidate round trip
    step(); cand(16'h100, 16'h40); sample();
    chk("t1_cand_ready", cand_ready, 1);
    chk("t1_req_not_yet", req_valid, 0);
    step(); cand_valid = 1'b0; sample();
    chk("t1_req_valid", req_valid, 1);
    chk("t1_req_tag", req_tag, 0);
    chk("t1_req_head", req_head, 16'h100);
    chk("t1_req_hist", req_hist, 16'h40);
    chk("t1_req_job", req_job, JOB);
    chk("t1_outstanding", outstanding, 1);
    step(); resp(JOB, 0, 17); sample();
    chk("t1_req_done", req_valid, 0);
    chk("t1_res_not_yet", res_valid, 0);
    step(); resp_valid = 1'b0; sample();
    chk("t1_res_valid", res_valid, 1);
    chk("t1_res_head", res_head, 16'h100);
    chk("t1_res_hist", res_hist, 16'h40);
    chk("t1_res_len", res_len, 17);
    step(); sample();
    chk("t1_res_gone", res_valid, 0);
    chk("t1_outstanding_0", outstanding, 0);

    // out-of-order responses 3,1,0,2
    do_reset();
    for (int i = 0; i < 4; i++) begin
      step(); cand(16'h200 + 16'(i), 16'h20 + 16'(i)); sample();
    end
    step(); cand_valid = 1'b0; sample();
    step(); sample();
    chk("t2_all_issued", req_valid, 0);
    chk("t2_outstanding", outstanding, 4);
    step(); resp(JOB, 3, 30); sample();
    chk("t2_hold_after3", res_valid, 0);
    step(); resp(JOB, 1, 31); sample();
    chk("t2_hold_after1", res_valid, 0);
    step(); resp(JOB, 0, 32); sample();
    chk("t2_same_cycle", res_valid, 0);
    step(); resp_valid = 1'b0; sample();
    chk("t2_r0_valid", res_valid, 1);
    chk("t2_r0_len", res_len, 32);
    chk("t2_r0_head", res_head, 16'h200);
    step(); sample();
    chk("t2_r1_valid", res_valid, 1);
    chk("t2_r1_len", res_len, 31);
    chk("t2_r1_head", res_head, 16'h201);
    step(); resp(JOB, 2, 33); sample();
    chk("t2_wait2", res_valid, 0);
    step(); resp_valid = 1'b0; sample();
    chk("t2_r2_valid", res_valid, 1);
    chk("t2_r2_len", res_len, 33);
    chk("t2_r2_head", res_head, 16'h202);
    step(); sample();
    chk("t2_r3_valid", res_valid, 1);
    chk("t2_r3_len", res_len, 30);
    chk("t2_r3_hist", res_hist, 16'h23);
    step(); sample();
    chk("t2_drained", res_valid, 0);
    chk("t2_outstanding_0", outstanding, 0);
    chk("t2_err", err, 0);

    // fill to full with results blocked
    do_reset();
    res_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      step(); cand(16'h300 + 16'(i), 16'h30 + 16'(i)); sample();
      chk("t3_fill_ready", cand_ready, 1);
    end
    step(); cand_valid = 1'b0; sample();
    chk("t3_full_ready", cand_ready, 0);
    chk("t3_full_outstanding", outstanding, DEPTH);
    step(); sample();
    chk("t3_all_issued", req_valid, 0);
    for (int t = 0; t < DEPTH; t++) begin
      step(); resp(JOB, t, 10 + t); sample();
    end
    step(); resp_valid = 1'b0; cand(16'h3ff, 16'h3f); res_ready = 1'b1; sample();
    chk("t3_head_valid", res_valid, 1);
    chk("t3_head_len", res_len, 10);
    chk("t3_full_same_cycle", cand_ready, 0);
    step(); cand_valid = 1'b0; res_ready = 1'b0; sample();
    chk("t3_freed_ready", cand_ready, 1);
    chk("t3_outstanding_7", outstanding, 7);
    chk("t3_next_len", res_len, 11);
    for (int i = 1; i < DEPTH; i++) begin
      step(); res_ready = 1'b1; sample();
      chk("t3_drain_valid", res_valid, 1);
      chk("t3_drain_len", res_len, 10 + i);
      chk("t3_drain_head", res_head, 16'h300 + 16'(i));
    end
    step(); sample();
    chk("t3_empty_res", res_valid, 0);
    chk("t3_empty_req", req_valid, 0);
    chk("t3_empty_outstanding", outstanding, 0);

    // 20 rounds across the wrap boundary
    exp_tag = 0;
    for (int r = 0; r < 20; r++) begin
      step(); cand(16'h400 + 16'(r), 16'h80 + 16'(r)); sample();
      step(); cand_valid = 1'b0; sample();
      chk("t4_req_valid", req_valid, 1);
      chk("t4_req_tag", req_tag, exp_tag);
      step(); resp(JOB, exp_tag, r + 1); sample();
      step(); resp_valid = 1'b0; sample();
      chk("t4_res_valid", res_valid, 1);
      chk("t4_res_head", res_head, 16'h400 + 16'(r));
      chk("t4_res_len", res_len, r + 1);
      step(); sample();
      chk("t4_outstanding", outstanding, 0);
      exp_tag = (exp_tag + 1) % DEPTH;
    end
    chk("t4_err", err, 0);

    // wrong job id
    do_reset();
    step(); cand(16'h500, 16'h50); sample();
    step(); cand_valid = 1'b0; sample();
    step(); resp(2, 0, 5); sample();
    chk("t5a_err_before", err, 0);
    step(); resp_valid = 1'b0; sample();
    chk("t5a_err", err, 1);
    chk("t5a_no_result", res_valid, 0);
    chk("t5a_outstanding", outstanding, 1);
    step(); resp(JOB, 0, 6); sample();
    step(); resp_valid = 1'b0; sample();
    chk("t5a_good_valid", res_valid, 1);
    chk("t5a_good_len", res_len, 6);
    chk("t5a_err_sticky", err, 1);
    step(); sample();

    // unissued tag
    do_reset();
    chk("t5b_err_cleared", err, 0);
    step(); cand(16'h510, 16'h51); sample();
    step(); cand_valid = 1'b0; sample();
    step(); resp(JOB, 5, 5); sample();
    step(); resp_valid = 1'b0; sample();
    chk("t5b_err", err, 1);
    chk("t5b_no_result", res_valid, 0);

    // duplicate response
    do_reset();
    res_ready = 1'b0;
    step(); cand(16'h520, 16'h52); sample();
    step(); cand_valid = 1'b0; sample();
    step(); resp(JOB, 0, 7); sample();
    step(); resp(JOB, 0, 9); sample();
    chk("t5c_first_valid", res_valid, 1);
    chk("t5c_first_len", res_len, 7);
    chk("t5c_err_before", err, 0);
    step(); resp_valid = 1'b0; sample();
    chk("t5c_err", err, 1);
    chk("t5c_len_kept", res_len, 7);
    chk("t5c_still_valid", res_valid, 1);
    step(); res_ready = 1'b1; sample();
    step(); sample();
    chk("t5c_retired", res_valid, 0);
    chk("t5c_outstanding", outstanding, 0);
    chk("t5c_err_sticky", err, 1);

    // reset with 5 outstanding
    do_reset();
    for (int i = 0; i < 5; i++) begin
      step(); cand(16'h600 + 16'(i), 16'h60); sample();
    end
    step(); cand_valid = 1'b0; sample();
    step(); sample();
    chk("t6_outstanding_5", outstanding, 5);
    step(); rst = 1'b1; sample();
    chk("t6_rst_cand_ready", cand_ready, 0);
    chk("t6_rst_req_valid", req_valid, 0);
    chk("t6_rst_resp_ready", resp_ready, 0);
    chk("t6_rst_outstanding", outstanding, 0);
    step(); rst = 1'b0; sample();
    chk("t6_after_outstanding", outstanding, 0);
    chk("t6_after_req_valid", req_valid, 0);
    chk("t6_after_res_valid", res_valid, 0);
    chk("t6_after_cand_ready", cand_ready, 1);
    chk("t6_after_err", err, 0);
    step(); resp(JOB, 2, 4); sample();
    step(); resp_valid = 1'b0; sample();
    chk("t6_stale_err", err, 1);
    chk("t6_stale_no_result", res_valid, 0);
    req_ready = 1'b0;
    step(); cand(16'h700, 16'h70); sample();
    step(); cand_valid = 1'b0; sample();
    chk("t6_req_valid", req_valid, 1);
    chk("t6_req_tag", req_tag, 0);
    chk("t6_req_head", req_head, 16'h700);
    step(); sample();
    chk("t6_stall_valid", req_valid, 1);
    chk("t6_stall_head", req_head, 16'h700);
    chk("t6_stall_hist", req_hist, 16'h70);
    step(); req_ready = 1'b1; sample();
    chk("t6_stall_tag", req_tag, 0);
    step(); resp(JOB, 0, 3); sample();
    chk("t6_req_done", req_valid, 0);
    step(); resp_valid = 1'b0; sample();
    chk("t6_res_valid", res_valid, 1);
    chk("t6_res_len", res_len, 3);
    chk("t6_res_head", res_head, 16'h700);
    step(); sample();
    chk("t6_outstanding_0", outstanding, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
